// File: rtl/im_loader.sv
// im_loader: framed byte-stream writer for the instruction memory.
// Frame = CNT_HI, CNT_LO, 4*N data bytes (big-endian words), CHK (XOR of data).
// Words land at consecutive IM word addresses from 0; busy holds the CPU.
module im_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t        state, state_nxt;
  logic [7:0]    cnt_hi;
  logic [15:0]   n_words;
  logic [AW:0]   word_cnt;      // one extra bit so N == DEPTH is reachable
  logic [AW:0]   word_cnt_inc;
  logic [1:0]    byte_idx;
  logic [7:0]    xor_acc;
  logic [31:0]   word_reg;
  logic [15:0]   hdr_n;
  logic          xfer;
  logic          idle_like;

  assign hdr_n        = {cnt_hi, byte_data};
  assign xfer         = byte_valid && byte_ready;
  assign word_cnt_inc = word_cnt + {{AW{1'b0}}, 1'b1};
  assign idle_like    = (state == IDLE) || (state == DONE);
  assign im_addr      = word_cnt[AW-1:0];
  assign im_wdata     = word_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake/strobe outputs
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    busy       = 1'b1;
    im_we      = 1'b0;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        if (start) state_nxt = HDR_HI;
      end
      HDR_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = HDR_LO;
      end
      HDR_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (hdr_n == 16'd0)        state_nxt = CHECK;
          else if (hdr_n > DEPTH_W)  state_nxt = DONE;
          else                       state_nxt = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (xfer && (byte_idx == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        im_we = 1'b1;
        // n_words never exceeds DEPTH here, so its low AW+1 bits are exact
        if (word_cnt_inc == n_words[AW:0]) state_nxt = CHECK;
        else                               state_nxt = DATA;
      end
      CHECK: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = DONE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Header latch, word assembly, checksum, word counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_hi   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      xor_acc  <= '0;
      word_reg <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (idle_like && start) begin
        done     <= 1'b0;
        err      <= 1'b0;
        word_cnt <= '0;
        byte_idx <= '0;
        xor_acc  <= '0;
      end
      case (state)
        HDR_HI: if (xfer) cnt_hi <= byte_data;
        HDR_LO: if (xfer) begin
          n_words <= hdr_n;
          if (hdr_n > DEPTH_W) err <= 1'b1;
        end
        DATA: if (xfer) begin
          word_reg <= {word_reg[23:0], byte_data};
          xor_acc  <= xor_acc ^ byte_data;
          byte_idx <= byte_idx + 2'd1;
        end
        WRITE: word_cnt <= word_cnt_inc;
        CHECK: if (xfer) begin
          if (byte_data == xor_acc) done <= 1'b1;
          else                      err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
